// File: rtl/addsub_pkg.sv
// addsub_pkg: shared op encoding and default widths for the add/subtract pipeline
package addsub_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  localparam int W_DEF = 8;
  localparam int LANES_DEF = 2;
  localparam int LAT_DEF = 2;
  localparam int SEQ_W_DEF = 8;
endpackage

// File: rtl/addsub_lane.sv
// addsub_lane: one-lane add/sub with carry/borrow; ADDSUB_SAT_EN adds saturation
module addsub_lane
  import addsub_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  op_e          op_i,
  output logic [W-1:0] y_o,
  output logic         carry_o
);
  logic [W:0] r;
  always_comb begin
    r = (op_i == OP_SUB) ? {1'b0, a_i} - {1'b0, b_i} : {1'b0, a_i} + {1'b0, b_i};
    carry_o = r[W];
`ifdef ADDSUB_SAT_EN
    y_o = r[W] ? ((op_i == OP_SUB) ? '0 : '1) : r[W-1:0];
`else
    y_o = r[W-1:0];
`endif
  end
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: multi-lane pipelined add/sub with valid/ready, global stall and result seq (ADDSUB_SAT_EN in lanes)
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] y,
  output logic [LANES-1:0]   carry,
  output logic [SEQ_W-1:0]   seq
);
  typedef struct packed {
    logic               valid;
    op_e                op;
    logic [LANES*W-1:0] y;
    logic [LANES-1:0]   carry;
  } stage_t;
  logic [LANES*W-1:0] y_lane;
  logic [LANES-1:0]   carry_lane;
  stage_t             st_q [LAT];
  stage_t             st_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               stall;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    addsub_lane #(.W(W)) u_lane (
      .a_i    (a[i*W +: W]),
      .b_i    (b[i*W +: W]),
      .op_i   (op_e'(op)),
      .y_o    (y_lane[i*W +: W]),
      .carry_o(carry_lane[i])
    );
  end
  always_comb begin
    stall = st_q[LAT-1].valid && !out_ready;
    in_ready = !stall && !rst;
    st_d = '{valid: in_valid && in_ready, op: op_e'(op), y: y_lane, carry: carry_lane};
    seq_d = seq_q + SEQ_W'(out_valid && out_ready);
  end
  // a stall freezes every stage, so bubbles never collapse and order is preserved
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) st_q[k] <= '0;
      seq_q <= '0;
    end else begin
      if (!stall) begin
        st_q[0] <= st_d;
        for (int k = 1; k < LAT; k++) st_q[k] <= st_q[k-1];
      end
      seq_q <= seq_d;
    end
  end
  assign out_valid = st_q[LAT-1].valid;
  assign y         = st_q[LAT-1].y;
  assign carry     = st_q[LAT-1].carry;
  assign seq       = seq_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: randomized self-checking bench for addsub_pipe (W=8, LANES=2, LAT=2)
module tb_addsub_pipe;
`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 0, rst = 1, in_valid = 0, op = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [15:0] a = '0, b = '0, y;
  logic [1:0] carry;
  logic [7:0] seq;
  int checks = 0, failures = 0;
  typedef struct packed {logic [15:0] y; logic [1:0] c;} res_t;
  res_t exp_q[$];
  int exp_seq = 0;
  always #5 clk = ~clk;
  addsub_pipe #(.W(8), .LANES(2), .LAT(2), .SEQ_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .carry(carry), .seq(seq)
  );
  function automatic res_t model(input bit o, input logic [15:0] aa, input logic [15:0] bb);
    res_t r;
    for (int i = 0; i < 2; i++) begin
      int x = int'(aa[i*8 +: 8]);
      int z = int'(bb[i*8 +: 8]);
      int s = o ? x - z : x + z;
      r.c[i] = o ? (x < z) : (s > 255);
      s = (s + 256) % 256;
      if (SAT && r.c[i]) s = o ? 0 : 255;
      r.y[i*8 +: 8] = s[7:0];
    end
    return r;
  endfunction
  task automatic cyc(input bit iv, input bit o, input logic [15:0] aa, input logic [15:0] bb,
                     input bit ordy, output bit acc, output bit ohs);
    @(negedge clk);
    in_valid = iv; op = o; a = aa; b = bb; out_ready = ordy;
    #1;
    acc = iv && in_ready;
    ohs = out_valid && ordy;
    if (acc) exp_q.push_back(model(o, aa, bb));
  endtask
  task automatic test_reset();
    in_valid = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({in_ready, out_valid, y, carry, seq} !== '0) begin
        failures++;
        $display("FAIL reset c=%0d: in_ready=%b out_valid=%b y=%h carry=%b seq=%0d, required all 0", c, in_ready, out_valid, y, carry, seq);
      end
    end
    rst = 0; in_valid = 0;
  endtask
  task automatic test_add();
    bit acc, ohs;
    res_t e;
    cyc(1, 0, 16'hFF12, 16'h0134, 1, acc, ohs);
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL add_accept: acc=%b required 1", acc); end
    cyc(0, 0, 0, 0, 1, acc, ohs);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL add_early: out_valid=%b required 0", out_valid); end
    cyc(0, 0, 0, 0, 1, acc, ohs);
    checks++;
    if ({out_valid, y, carry, seq} !== {1'b1, (SAT ? 16'hFF46 : 16'h0046), 2'b10, 8'd0}) begin
      failures++;
      $display("FAIL add_result: v=%b y=%h c=%b seq=%0d required v=1 y=%h c=10 seq=0", out_valid, y, carry, seq, SAT ? 16'hFF46 : 16'h0046);
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    exp_seq++;
  endtask
  task automatic test_sub();
    bit acc, ohs;
    res_t e;
    cyc(1, 1, 16'h8005, 16'h0107, 1, acc, ohs);
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL sub_accept: acc=%b required 1", acc); end
    cyc(0, 0, 0, 0, 1, acc, ohs);
    cyc(0, 0, 0, 0, 1, acc, ohs);
    checks++;
    if ({out_valid, y, carry, seq} !== {1'b1, (SAT ? 16'h7F00 : 16'h7FFE), 2'b01, 8'd1}) begin
      failures++;
      $display("FAIL sub_result: v=%b y=%h c=%b seq=%0d required v=1 y=%h c=01 seq=1", out_valid, y, carry, seq, SAT ? 16'h7F00 : 16'h7FFE);
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    exp_seq++;
  endtask
  task automatic test_backpressure();
    int sent = 0, got = 0;
    bit acc, ohs;
    logic [25:0] snap = '0;
    logic [15:0] aa = 16'($urandom), bb = 16'($urandom);
    bit o = 1'($urandom);
    for (int c = 0; c < 40 && got < 4; c++) begin
      bit ordy = !(c >= 2 && c <= 4);
      cyc(sent < 4, o, aa, bb, ordy, acc, ohs);
      if (acc) begin sent++; aa = 16'($urandom); bb = 16'($urandom); o = 1'($urandom); end
      if (!ordy) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_stall c=%0d: in_ready=%b out_valid=%b required 0/1", c, in_ready, out_valid);
        end
        if (c > 2) begin
          checks++;
          if ({y, carry, seq} !== snap) begin
            failures++;
            $display("FAIL bp_hold c=%0d: got %h required %h", c, {y, carry, seq}, snap);
          end
        end else snap = {y, carry, seq};
      end
      if (ohs) begin
        res_t e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        checks++;
        if ({y, carry, seq} !== {e.y, e.c, 8'(exp_seq)}) begin
          failures++;
          $display("FAIL bp_out: y=%h c=%b seq=%0d required y=%h c=%b seq=%0d", y, carry, seq, e.y, e.c, exp_seq % 256);
        end
        exp_seq++; got++;
      end
    end
    checks++;
    if (got != 4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_count: got=%0d left=%0d required 4/0", got, exp_q.size());
    end
  endtask
  task automatic test_wrap();
    int sent = 0, got = 0, first_c = -1, last_c = -1;
    bit acc, ohs;
    for (int c = 0; c < 300 && got < 257; c++) begin
      cyc(sent < 257, 1'($urandom), 16'($urandom), 16'($urandom), 1, acc, ohs);
      if (acc) sent++;
      if (ohs) begin
        res_t e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        checks++;
        if ({y, carry, seq} !== {e.y, e.c, 8'(exp_seq)}) begin
          failures++;
          $display("FAIL wrap_out n=%0d: y=%h c=%b seq=%0d required y=%h c=%b seq=%0d", got, y, carry, seq, e.y, e.c, exp_seq % 256);
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        exp_seq++; got++;
      end
    end
    checks++;
    if (got != 257 || first_c != 2 || last_c != 258) begin
      failures++;
      $display("FAIL wrap_rate: got=%0d first=%0d last=%0d required 257/2/258", got, first_c, last_c);
    end
  endtask
  task automatic test_mid_reset();
    bit acc, ohs;
    int lat = -1;
    cyc(1, 0, 16'($urandom), 16'($urandom), 1, acc, ohs);
    cyc(1, 1, 16'($urandom), 16'($urandom), 1, acc, ohs);
    @(negedge clk);
    rst = 1; in_valid = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL mr_ready: in_ready=%b required 0", in_ready); end
    @(negedge clk);
    rst = 0; in_valid = 0;
    exp_q.delete(); exp_seq = 0;
    #1;
    checks++;
    if ({out_valid, y, carry, seq} !== '0) begin
      failures++;
      $display("FAIL mr_clear: v=%b y=%h c=%b seq=%0d required all 0", out_valid, y, carry, seq);
    end
    for (int c = 0; c < 4; c++) begin
      cyc(0, 0, 0, 0, 1, acc, ohs);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mr_idle c=%0d: out_valid=%b required 0", c, out_valid); end
    end
    cyc(1, 1'($urandom), 16'($urandom), 16'($urandom), 1, acc, ohs);
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL mr_accept: acc=%b required 1", acc); end
    for (int c = 0; c < 10 && lat < 0; c++) begin
      cyc(0, 0, 0, 0, 1, acc, ohs);
      if (ohs) begin
        res_t e;
        e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        lat = c;
        checks++;
        if ({y, carry, seq} !== {e.y, e.c, 8'(exp_seq)}) begin
          failures++;
          $display("FAIL mr_out: y=%h c=%b seq=%0d required y=%h c=%b seq=0", y, carry, seq, e.y, e.c);
        end
        exp_seq++;
      end
    end
    checks++;
    if (lat != 1) begin failures++; $display("FAIL mr_latency: first output at %0d required 1", lat); end
  endtask
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
